// File: rtl/sha3_msg_feeder.sv
// sha3_msg_feeder: buffers BUS_W-bit OCM beats and streams them as 64-bit Keccak words with is_last/byte_num termination.
// Define SHA3_FEEDER_BYTESWAP_EN to byte-reverse every lane before it reaches keccak_input.
module sha3_msg_feeder #(
    parameter int BUS_W      = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_bytes,
    output logic             busy,
    output logic             done,
    output logic             overflow_err,
    input  logic [BUS_W-1:0] ocm_data_out,
    input  logic             bus_data_valid,
    output logic             dfsm_read_ready,
    output logic [31:0]      read_addr_offset,
    output logic [63:0]      keccak_input,
    output logic             in_ready,
    output logic             is_last,
    output logic [2:0]       byte_num,
    input  logic             buffer_full
);
    localparam int L  = BUS_W / 64;
    localparam int BB = BUS_W / 8;
    localparam int LW = L > 1 ? $clog2(L) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FEED, PAD, DONE} state_t;

    state_t           state;
    logic [BUS_W-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, cnt_n;
    logic [LEN_W-1:0] beats_total, words_total, beats_rcvd, words_sent, rcvd_n;
    logic [LEN_W:0]   beats_calc;
    logic [2:0]       tail;
    logic [LW-1:0]    lane;
    logic [63:0]      head, word;
    logic             push, issue, fin, pop;

    always_comb begin
        push       = bus_data_valid && dfsm_read_ready;
        head       = fifo[rd_ptr][{lane, 6'b0} +: 64];
        issue      = state == FEED && count != '0 && !buffer_full;
        fin        = words_sent == (tail == 3'd0 ? words_total - 1'b1 : words_total);
        pop        = issue && (lane == LW'(L - 1) || fin);
        cnt_n      = count + CW'(push) - CW'(pop);
        rcvd_n     = beats_rcvd + LEN_W'(push);
        beats_calc = ({1'b0, msg_bytes} + (LEN_W+1)'(BB - 1)) / (LEN_W+1)'(BB);
        word       = head;
`ifdef SHA3_FEEDER_BYTESWAP_EN
        for (int i = 0; i < 8; i++) word[8*i +: 8] = head[8*(7-i) +: 8];
`endif
    end

    always_ff @(posedge clk) if (push) fifo[wr_ptr] <= ocm_data_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            overflow_err     <= 1'b0;
            dfsm_read_ready  <= 1'b0;
            read_addr_offset <= '0;
            keccak_input     <= '0;
            in_ready         <= 1'b0;
            is_last          <= 1'b0;
            byte_num         <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            lane             <= '0;
            beats_total      <= '0;
            words_total      <= '0;
            beats_rcvd       <= '0;
            words_sent       <= '0;
            tail             <= '0;
        end else begin
            done         <= 1'b0;
            in_ready     <= 1'b0;
            is_last      <= 1'b0;
            byte_num     <= '0;
            keccak_input <= '0;
            if (bus_data_valid && !dfsm_read_ready) overflow_err <= 1'b1;
            if (push) begin
                wr_ptr           <= wr_ptr + 1'b1;
                beats_rcvd       <= rcvd_n;
                read_addr_offset <= read_addr_offset + 32'(BB);
            end
            count           <= cnt_n;
            dfsm_read_ready <= state == FEED && rcvd_n < beats_total && cnt_n < CW'(FIFO_DEPTH);
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                lane   <= '0;
            end else if (issue) lane <= lane + 1'b1;
            case (state)
                IDLE: if (start) begin
                    state            <= msg_bytes == '0 ? PAD : FEED;
                    busy             <= 1'b1;
                    dfsm_read_ready  <= msg_bytes != '0;
                    overflow_err     <= 1'b0;
                    read_addr_offset <= '0;
                    beats_total      <= beats_calc[LEN_W-1:0];
                    words_total      <= msg_bytes >> 3;
                    tail             <= msg_bytes[2:0];
                    beats_rcvd       <= '0;
                    words_sent       <= '0;
                end
                FEED: if (issue) begin
                    in_ready     <= 1'b1;
                    keccak_input <= word;
                    is_last      <= fin;
                    byte_num     <= fin ? tail : 3'd0;
                    words_sent   <= words_sent + 1'b1;
                    if (fin) state <= tail == 3'd0 ? PAD : DONE;
                end
                PAD: if (!buffer_full) begin
                    in_ready <= 1'b1;
                    is_last  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    lane   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha3_msg_feeder.sv
// tb_sha3_msg_feeder: directed messages against an OCM model; expected words are queued at start and checked by a monitor.
module tb_sha3_msg_feeder;
    logic         clk, reset_n, start, busy, done, overflow_err;
    logic [15:0]  msg_bytes;
    logic [127:0] ocm_data_out;
    logic         bus_data_valid, dfsm_read_ready;
    logic [31:0]  read_addr_offset;
    logic [63:0]  keccak_input;
    logic         in_ready, is_last, buffer_full;
    logic [2:0]   byte_num;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [2:0]  n;
    } exp_t;

    exp_t exp_q[$];
    int   total, bad, cyc, last_cyc, seed;
    logic inj, tog, rdy_seen, bf_q;

    sha3_msg_feeder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .msg_bytes(msg_bytes),
        .busy(busy), .done(done), .overflow_err(overflow_err),
        .ocm_data_out(ocm_data_out), .bus_data_valid(bus_data_valid),
        .dfsm_read_ready(dfsm_read_ready), .read_addr_offset(read_addr_offset),
        .keccak_input(keccak_input), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        bf_q <= buffer_full;
    end

    function automatic logic [7:0] byte_at(input int a);
        return 8'(a * 37 + seed * 11 + 3);
    endfunction

    function automatic logic [127:0] beat_at(input logic [31:0] a);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = byte_at(int'(a) + b);
        return r;
    endfunction

    function automatic logic [63:0] word_at(input int j);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = byte_at(8 * j + b);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (dfsm_read_ready) rdy_seen = 1'b1;
        if (tog) buffer_full = ~buffer_full;
        if (inj) begin
            bus_data_valid = 1'b1;
            ocm_data_out   = '1;
        end else if (dfsm_read_ready) begin
            bus_data_valid = 1'b1;
            ocm_data_out   = beat_at(read_addr_offset);
        end else bus_data_valid = 1'b0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (in_ready) begin
            chk("in_ready_after_buffer_full", 64'(bf_q), 64'd0);
            if (exp_q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("word_data", keccak_input, e.d);
                chk("word_is_last", 64'(is_last), 64'(e.l));
                chk("word_byte_num", 64'(byte_num), 64'(e.n));
                if (is_last) last_cyc = cyc;
            end
        end
    end

    task automatic start_msg(input int n);
        int w = n / 8;
        int t = n % 8;
        seed++;
        for (int j = 0; j < w; j++) exp_q.push_back('{word_at(j), t == 0 && j == w - 1, 3'd0});
        if (t != 0) exp_q.push_back('{word_at(w), 1'b1, 3'(t)});
        else exp_q.push_back('{64'd0, 1'b1, 3'd0});
        @(negedge clk);
        start     = 1'b1;
        msg_bytes = 16'(n);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("ready_after_start", 64'(dfsm_read_ready), 64'(n != 0));
        chk("overflow_cleared_by_start", 64'(overflow_err), 64'd0);
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("all_words_delivered", 64'(exp_q.size()), 64'd0);
        chk("final_read_addr", 64'(read_addr_offset), 64'((n + 15) / 16 * 16));
        chk("done_lag_after_last", 64'(cyc - last_cyc), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_single_pulse", 64'(done), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        chk("rst_ready", 64'(dfsm_read_ready), 64'd0);
        chk("rst_addr", 64'(read_addr_offset), 64'd0);
        chk("rst_keccak_input", keccak_input, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_is_last", 64'(is_last), 64'd0);
        chk("rst_byte_num", 64'(byte_num), 64'd0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; last_cyc = 0; seed = 0;
        inj = 1'b0; tog = 1'b0; rdy_seen = 1'b0;
        start = 1'b0; msg_bytes = '0; buffer_full = 1'b0;
        bus_data_valid = 1'b0; ocm_data_out = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset_n = 1'b1;

        start_msg(32);
        wait_done(32);
        start_msg(21);
        wait_done(21);

        rdy_seen = 1'b0;
        start_msg(0);
        wait_done(0);
        chk("ready_never_for_empty_msg", 64'(rdy_seen), 64'd0);

        tog = 1'b1;
        start_msg(64);
        wait_done(64);
        tog = 1'b0;
        @(negedge clk);
        buffer_full = 1'b0;

        buffer_full = 1'b1;
        start_msg(64);
        repeat (12) @(negedge clk);
        chk("fifo_full_ready_low", 64'(dfsm_read_ready), 64'd0);
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        chk("overflow_set", 64'(overflow_err), 64'd1);
        buffer_full = 1'b0;
        wait_done(64);
        chk("overflow_sticky", 64'(overflow_err), 64'd1);

        buffer_full = 1'b1;
        start_msg(64);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        exp_q.delete();
        reset_n = 1'b1;
        buffer_full = 1'b0;
        @(negedge clk);
        start_msg(8);
        wait_done(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
